// File: rtl/kernel_sram_ctrl.sv
// Kernel SRAM controller: streams coefficient sets into per-channel banks
// (bank-major) and replays one set as a COEFS-long read burst across all banks.
module kernel_sram_ctrl #(
    parameter int WIDTH     = 16,
    parameter int HEIGHT    = 128,
    parameter int NUM_BANKS = 16,
    parameter int COEFS     = 18,
    localparam int NUM_SETS = HEIGHT / COEFS,
    localparam int SETW     = $clog2(NUM_SETS),
    localparam int AW       = $clog2(HEIGHT)
) (
    input  logic                 clk,
    input  logic                 arst_n_in,
    input  logic                 load_start,
    input  logic [SETW-1:0]      load_set,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic                 read_start,
    input  logic [SETW-1:0]      read_set,
    output logic [AW-1:0]        KERNEL_write_addr,
    output logic [WIDTH-1:0]     KERNEL_din,
    output logic [NUM_BANKS-1:0] KERNEL_we,
    output logic [AW-1:0]        KERNEL_read_addr,
    output logic                 KERNEL_re,
    output logic                 coef_valid,
    output logic [4:0]           coef_idx,
    output logic                 busy,
    output logic                 load_done,
    output logic                 read_done,
    output logic                 set_err
);
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam logic [SETW:0]   SET_LIM = (SETW+1)'(NUM_SETS);
    localparam logic [4:0]      C_LAST  = 5'(COEFS - 1);
    localparam logic [BW-1:0]   B_LAST  = BW'(NUM_BANKS - 1);

    logic [1:0]      state_q, state_d;
    logic [SETW-1:0] set_q, set_d;
    logic [BW-1:0]   b_q, b_d;
    logic [4:0]      c_q, c_d;
    logic            load_done_q, load_done_d;
    logic            set_err_q, set_err_d;
    logic [AW-1:0]   raddr_q;
    logic            coef_valid_q;
    logic [4:0]      coef_idx_q;

    logic            wr;
    logic [AW-1:0]   cur_addr;

    assign din_ready = (state_q == LOAD);
    assign KERNEL_re = (state_q == READ);
    assign wr        = din_valid && din_ready;
    assign cur_addr  = AW'(int'(set_q) * COEFS + int'(c_q));

    // Write side is fully gated so the SRAM bus idles at zero between words.
    assign KERNEL_we         = wr ? (NUM_BANKS'(1) << b_q) : '0;
    assign KERNEL_write_addr = wr ? cur_addr : '0;
    assign KERNEL_din        = wr ? din : '0;
    assign KERNEL_read_addr  = KERNEL_re ? cur_addr : raddr_q;

    assign coef_valid = coef_valid_q;
    assign coef_idx   = coef_idx_q;
    assign busy       = (state_q != IDLE);
    assign load_done  = load_done_q;
    assign read_done  = (state_q == DRAIN);
    assign set_err    = set_err_q;

    always_comb begin
        state_d     = state_q;
        set_d       = set_q;
        b_d         = b_q;
        c_d         = c_q;
        load_done_d = 1'b0;
        set_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // Load wins over a simultaneous read; the read is simply dropped.
                if (load_start) begin
                    if ({1'b0, load_set} < SET_LIM) begin
                        state_d = LOAD;
                        set_d   = load_set;
                        b_d     = '0;
                        c_d     = '0;
                    end else begin
                        set_err_d = 1'b1;
                    end
                end else if (read_start) begin
                    if ({1'b0, read_set} < SET_LIM) begin
                        state_d = READ;
                        set_d   = read_set;
                        c_d     = '0;
                    end else begin
                        set_err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (wr) begin
                    if (c_q == C_LAST) begin
                        c_d = '0;
                        b_d = b_q + BW'(1);
                        if (b_q == B_LAST) begin
                            state_d     = IDLE;
                            load_done_d = 1'b1;
                        end
                    end else begin
                        c_d = c_q + 5'd1;
                    end
                end
            end
            READ: begin
                if (c_q == C_LAST) begin
                    c_d     = '0;
                    state_d = DRAIN;
                end else begin
                    c_d = c_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q      <= IDLE;
            set_q        <= '0;
            b_q          <= '0;
            c_q          <= '0;
            load_done_q  <= 1'b0;
            set_err_q    <= 1'b0;
            raddr_q      <= '0;
            coef_valid_q <= 1'b0;
            coef_idx_q   <= '0;
        end else begin
            state_q      <= state_d;
            set_q        <= set_d;
            b_q          <= b_d;
            c_q          <= c_d;
            load_done_q  <= load_done_d;
            set_err_q    <= set_err_d;
            if (KERNEL_re) raddr_q <= cur_addr;
            // SRAM qout lags the read strobe by exactly one cycle.
            coef_valid_q <= KERNEL_re;
            coef_idx_q   <= KERNEL_re ? c_q : 5'd0;
        end
    end
endmodule

// File: tb/tb_kernel_sram_ctrl.sv
// Directed bench for kernel_sram_ctrl: loads, stalls, reads, range errors and
// mid-load reset, each against hand-computed expectations.
module tb_kernel_sram_ctrl;
    localparam int WIDTH = 16;
    localparam int AW    = 7;
    localparam int SETW  = 3;
    localparam int NB    = 16;

    logic             clk = 1'b0;
    logic             arst_n_in;
    logic             load_start, read_start, din_valid;
    logic [SETW-1:0]  load_set, read_set;
    logic [WIDTH-1:0] din;
    logic             din_ready, KERNEL_re, coef_valid, busy, load_done, read_done, set_err;
    logic [AW-1:0]    KERNEL_write_addr, KERNEL_read_addr;
    logic [WIDTH-1:0] KERNEL_din;
    logic [NB-1:0]    KERNEL_we;
    logic [4:0]       coef_idx;

    int checks = 0;
    int errors = 0;
    int ldcyc;

    always #5 clk = ~clk;

    kernel_sram_ctrl dut (
        .clk(clk), .arst_n_in(arst_n_in),
        .load_start(load_start), .load_set(load_set),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .read_start(read_start), .read_set(read_set),
        .KERNEL_write_addr(KERNEL_write_addr), .KERNEL_din(KERNEL_din),
        .KERNEL_we(KERNEL_we), .KERNEL_read_addr(KERNEL_read_addr),
        .KERNEL_re(KERNEL_re), .coef_valid(coef_valid), .coef_idx(coef_idx),
        .busy(busy), .load_done(load_done), .read_done(read_done), .set_err(set_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 32'({KERNEL_we, KERNEL_re, din_ready, coef_valid, coef_idx,
                               busy, load_done, read_done, set_err}), 32'd0);
        chk({tag, "_bus"}, 32'({KERNEL_write_addr, KERNEL_read_addr, KERNEL_din}), 32'd0);
    endtask

    initial begin
        arst_n_in = 1'b0; load_start = 1'b0; read_start = 1'b0; din_valid = 1'b0;
        load_set = '0; read_set = '0; din = '0;
        repeat (2) @(negedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk) arst_n_in = 1'b1;

        // Load set 2, din_valid always high: word k -> bank k/18, addr 36+k%18
        @(negedge clk) load_start = 1'b1; load_set = 3'd2;
        #1 chk("idle_ready", 32'(din_ready), 32'd0);
        for (int k = 0; k < 288; k++) begin
            @(negedge clk) load_start = 1'b0; din = 16'(k); din_valid = 1'b1;
            #1;
            chk("ld_we",   32'(KERNEL_we), 32'(1) << (k / 18));
            chk("ld_addr", 32'(KERNEL_write_addr), 32'(36 + k % 18));
            chk("ld_din",  32'(KERNEL_din), 32'(k));
        end
        @(negedge clk) din_valid = 1'b0;
        #1 chk("ld_done", 32'({load_done, busy, KERNEL_we}), 32'h1_0000 << 1);
        @(negedge clk);
        #1 chk("ld_done_pulse", 32'(load_done), 32'd0);

        // Same load with din_valid on every other cycle: 576 cycles in LOAD
        @(negedge clk) load_start = 1'b1; load_set = 3'd2;
        ldcyc = 0;
        for (int i = 0; i < 576; i++) begin
            @(negedge clk) load_start = 1'b0; din_valid = i[0]; din = 16'(i / 2);
            #1;
            if (din_ready) ldcyc++;
            chk("st_we", 32'(KERNEL_we), i[0] ? (32'(1) << ((i / 2) / 18)) : 32'd0);
            if (i[0]) chk("st_addr", 32'(KERNEL_write_addr), 32'(36 + (i / 2) % 18));
        end
        @(negedge clk) din_valid = 1'b0;
        #1;
        chk("st_done", 32'(load_done), 32'd1);
        chk("st_cycles", 32'(ldcyc), 32'd576);

        // Read set 6: re for 18 cycles at 108..125, qout valid one cycle later
        @(negedge clk) read_start = 1'b1; read_set = 3'd6;
        for (int j = 1; j <= 21; j++) begin
            @(negedge clk) read_start = (j == 19); read_set = '0;
            #1;
            chk("rd_re", 32'(KERNEL_re), 32'(j <= 18));
            if (j <= 18) chk("rd_addr", 32'(KERNEL_read_addr), 32'(107 + j));
            if (j >= 20) chk("rd_hold", 32'(KERNEL_read_addr), 32'd125);
            chk("rd_cv", 32'(coef_valid), 32'(j >= 2 && j <= 19));
            if (j >= 2 && j <= 19) chk("rd_idx", 32'(coef_idx), 32'(j - 2));
            chk("rd_done", 32'(read_done), 32'(j == 19));
            chk("rd_busy", 32'(busy), 32'(j <= 19));
        end

        // Simultaneous load+read starts load only; reads during LOAD ignored
        @(negedge clk) load_start = 1'b1; read_start = 1'b1; load_set = 3'd0; read_set = 3'd1;
        @(negedge clk) load_start = 1'b0; read_set = 3'd3; din_valid = 1'b0;
        #1 chk("both_ld", 32'({din_ready, KERNEL_re, busy}), 32'b101);
        for (int k = 0; k < 288; k++) begin
            @(negedge clk) read_start = (k < 5); din = 16'(k + 1000); din_valid = 1'b1;
            #1;
            chk("both_re", 32'(KERNEL_re), 32'd0);
            chk("both_we", 32'(KERNEL_we), 32'(1) << (k / 18));
            if (k < 18) chk("both_addr", 32'(KERNEL_write_addr), 32'(k));
        end
        @(negedge clk) din_valid = 1'b0; read_start = 1'b0;
        #1 chk("both_done", 32'(load_done), 32'd1);

        // Out-of-range sets: set_err pulse, stay IDLE
        @(negedge clk) read_start = 1'b1; read_set = 3'd7;
        @(negedge clk) read_start = 1'b0;
        #1 chk("rerr", 32'({set_err, busy, KERNEL_re}), 32'b100);
        @(negedge clk);
        #1 chk("rerr_after", 32'({set_err, busy, KERNEL_re}), 32'b000);
        @(negedge clk) load_start = 1'b1; load_set = 3'd7;
        @(negedge clk) load_start = 1'b0;
        #1 chk("lerr", 32'({set_err, busy, din_ready}), 32'b100);

        // Reset after 100 accepted words, then a fresh load restarts at bank 0
        @(negedge clk) load_start = 1'b1; load_set = 3'd1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk) load_start = 1'b0; din = 16'(k + 500); din_valid = 1'b1;
        end
        @(negedge clk) arst_n_in = 1'b0;
        #1 chk_all_zero("mid_rst");
        repeat (3) begin
            @(negedge clk);
            #1 chk_all_zero("rst_hold");
        end
        @(negedge clk) arst_n_in = 1'b1; load_start = 1'b1; load_set = 3'd1; din_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk) load_start = 1'b0; din = 16'(k); din_valid = 1'b1;
            #1;
            chk("re_we", 32'(KERNEL_we), 32'd1);
            chk("re_addr", 32'(KERNEL_write_addr), 32'(18 + k));
        end
        @(negedge clk) din_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
